// File: rtl/adc_sample_avg.sv
// -----------------------------------------------------------------------------
// adc_sample_avg
//   Consumer of the 8-bit ADC stage. It watches the ADC busy line for a
//   completed conversion (busy falling 1->0), captures the sample on that
//   cycle and block-averages 2^AVG_LOG2 samples. Each average goes out on a
//   valid/ready interface. The block also drives a hysteresis threshold
//   alarm and a sticky overrun flag.
//
//   Optional feature macro: MINMAX_TRACK_EN
//     When defined, the blk_min/blk_max outputs report the smallest and
//     largest raw samples of the last completed block.
//
// Ports
//   clk        in   1  clock, all logic on posedge
//   rst        in   1  synchronous reset, active-high
//   en         in   1  block enable; low discards the partial block
//   adc_busy   in   1  busy from the ADC stage
//   adc_dout   in   8  ADC sample, valid in the cycle where busy is low
//   avg_data   out  8  averaged sample (truncated)
//   avg_valid  out  1  avg_data holds an unconsumed result
//   avg_ready  in   1  consumer accepts when avg_valid && avg_ready
//   alarm      out  1  hysteresis alarm (set >= TH_HI, clear <= TH_LO)
//   overrun    out  1  sticky: a result overwrote an unconsumed one
//   clr_ovr    in   1  pulse clears overrun (a new overrun event wins)
//   blk_min    out  8  (MINMAX_TRACK_EN only) min sample of the last block
//   blk_max    out  8  (MINMAX_TRACK_EN only) max sample of the last block
// -----------------------------------------------------------------------------
module adc_sample_avg #(
    parameter int          AVG_LOG2 = 2,
    parameter logic [7:0]  TH_HI    = 8'hC0,
    parameter logic [7:0]  TH_LO    = 8'h40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        adc_busy,
    input  logic [7:0]  adc_dout,
    output logic [7:0]  avg_data,
    output logic        avg_valid,
    input  logic        avg_ready,
    output logic        alarm,
    output logic        overrun,
    input  logic        clr_ovr
`ifdef MINMAX_TRACK_EN
    ,
    output logic [7:0]  blk_min,
    output logic [7:0]  blk_max
`endif
);

    // Sum width: 2^AVG_LOG2 samples of 0xFF fit exactly without overflow.
    localparam int SUM_W = 8 + AVG_LOG2;
    localparam logic [AVG_LOG2-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    state_t                 state_reg;
    logic                   busy_q_reg;
    logic [SUM_W-1:0]       sum_reg;
    logic [AVG_LOG2-1:0]    cnt_reg;
    logic [7:0]             avg_data_reg;
    logic                   avg_valid_reg;
    logic                   alarm_reg;
    logic                   overrun_reg;

    logic                   smp;
    logic                   emit;
    logic                   accept;
    logic [7:0]             avg_next;

    // Conversion-complete strobe: registered busy high, live busy low.
    assign smp      = en && busy_q_reg && !adc_busy;
    // A completed block is only published while enabled; dropping en
    // wins over every state action.
    assign emit     = en && (state_reg == ST_EMIT);
    assign accept   = avg_valid_reg && avg_ready;
    assign avg_next = sum_reg[SUM_W-1:AVG_LOG2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            busy_q_reg    <= 1'b0;
            sum_reg       <= '0;
            cnt_reg       <= '0;
            avg_data_reg  <= 8'h00;
            avg_valid_reg <= 1'b0;
            alarm_reg     <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            busy_q_reg <= adc_busy;

            if (!en) begin
                state_reg <= ST_IDLE;
                sum_reg   <= '0;
                cnt_reg   <= '0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        state_reg <= ST_ACC;
                        sum_reg   <= '0;
                        cnt_reg   <= '0;
                    end
                    ST_ACC: begin
                        if (smp) begin
                            sum_reg <= sum_reg + SUM_W'(adc_dout);
                            // cnt wraps to zero naturally at the block end
                            cnt_reg <= cnt_reg + 1'b1;
                            if (cnt_reg == CNT_MAX) begin
                                state_reg <= ST_EMIT;
                            end
                        end
                    end
                    ST_EMIT: begin
                        avg_data_reg <= avg_next;
                        sum_reg      <= '0;
                        cnt_reg      <= '0;
                        state_reg    <= ST_ACC;
                        // Hysteresis: between the thresholds the alarm holds.
                        if (avg_next >= TH_HI) begin
                            alarm_reg <= 1'b1;
                        end else if (avg_next <= TH_LO) begin
                            alarm_reg <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end

            // A fresh result keeps valid high even if the old one is
            // accepted in the same cycle.
            if (emit) begin
                avg_valid_reg <= 1'b1;
            end else if (accept) begin
                avg_valid_reg <= 1'b0;
            end

            // Set has priority over the clear pulse.
            if (emit && avg_valid_reg && !avg_ready) begin
                overrun_reg <= 1'b1;
            end else if (clr_ovr) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign avg_data  = avg_data_reg;
    assign avg_valid = avg_valid_reg;
    assign alarm     = alarm_reg;
    assign overrun   = overrun_reg;

`ifdef MINMAX_TRACK_EN
    logic [7:0] min_w_reg;
    logic [7:0] max_w_reg;
    logic [7:0] blk_min_reg;
    logic [7:0] blk_max_reg;

    // Working trackers restart at the extremes every block; the published
    // values move together with avg_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            min_w_reg   <= 8'hFF;
            max_w_reg   <= 8'h00;
            blk_min_reg <= 8'h00;
            blk_max_reg <= 8'h00;
        end else if (!en || state_reg == ST_IDLE) begin
            min_w_reg <= 8'hFF;
            max_w_reg <= 8'h00;
        end else if (state_reg == ST_ACC) begin
            if (smp) begin
                if (adc_dout < min_w_reg) begin
                    min_w_reg <= adc_dout;
                end
                if (adc_dout > max_w_reg) begin
                    max_w_reg <= adc_dout;
                end
            end
        end else if (state_reg == ST_EMIT) begin
            blk_min_reg <= min_w_reg;
            blk_max_reg <= max_w_reg;
            min_w_reg   <= 8'hFF;
            max_w_reg   <= 8'h00;
        end
    end

    assign blk_min = blk_min_reg;
    assign blk_max = blk_max_reg;
`endif

endmodule

// File: tb/tb_adc_sample_avg.sv
// -----------------------------------------------------------------------------
// tb_adc_sample_avg
//   Directed bench for adc_sample_avg (AVG_LOG2=2, TH_HI=0xC0, TH_LO=0x40).
//   Each ADC conversion is emulated as busy high for two cycles followed by
//   one low cycle carrying the sample. Expected values are hand-computed.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_adc_sample_avg;

    logic       clk;
    logic       rst;
    logic       en;
    logic       adc_busy;
    logic [7:0] adc_dout;
    logic [7:0] avg_data;
    logic       avg_valid;
    logic       avg_ready;
    logic       alarm;
    logic       overrun;
    logic       clr_ovr;
`ifdef MINMAX_TRACK_EN
    logic [7:0] blk_min;
    logic [7:0] blk_max;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    adc_sample_avg #(
        .AVG_LOG2 (2),
        .TH_HI    (8'hC0),
        .TH_LO    (8'h40)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .adc_busy  (adc_busy),
        .adc_dout  (adc_dout),
        .avg_data  (avg_data),
        .avg_valid (avg_valid),
        .avg_ready (avg_ready),
        .alarm     (alarm),
        .overrun   (overrun),
        .clr_ovr   (clr_ovr)
`ifdef MINMAX_TRACK_EN
        ,
        .blk_min   (blk_min),
        .blk_max   (blk_max)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Move to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One conversion; called just after a rising edge, returns just after
    // the edge that samples the strobe.
    task automatic do_sample(input logic [7:0] v);
        adc_busy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        adc_busy = 1'b0;
        adc_dout = v;
        @(posedge clk);
        #1;
    endtask

    // Four samples, then park on the falling edge after the emit edge.
    task automatic blk4(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d);
        do_sample(a);
        do_sample(b);
        do_sample(c);
        do_sample(d);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        adc_busy  = 1'b0;
        adc_dout  = 8'h00;
        avg_ready = 1'b1;
        clr_ovr   = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data",    avg_data,  8'h00);
        check("rst_valid",   avg_valid, 1'b0);
        check("rst_alarm",   alarm,     1'b0);
        check("rst_overrun", overrun,   1'b0);
`ifdef MINMAX_TRACK_EN
        check("rst_min", blk_min, 8'h00);
        check("rst_max", blk_max, 8'h00);
`endif

        step();
        rst = 1'b0;
        en  = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 4,8,12,16 -> 10, valid two edges after the last strobe, one cycle wide
        do_sample(8'd4);
        do_sample(8'd8);
        do_sample(8'd12);
        do_sample(8'd16);
        @(negedge clk);
        check("lat_not_yet", avg_valid, 1'b0);
        @(negedge clk);
        check("avg10_valid", avg_valid, 1'b1);
        check("avg10_data",  avg_data,  8'd10);
        check("avg10_alarm", alarm,     1'b0);
        @(negedge clk);
        check("avg10_taken", avg_valid, 1'b0);
        step();

        // Full-scale block: no overflow
        blk4(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        check("ff_data",  avg_data, 8'hFF);
        check("ff_alarm", alarm,    1'b1);
        step();

        // 13/4 truncates to 3
        blk4(8'd3, 8'd3, 8'd3, 8'd4);
        check("trunc_data",  avg_data, 8'd3);
        check("trunc_alarm", alarm,    1'b0);
        step();

        // Consumer stalled across two blocks
        avg_ready = 1'b0;
        blk4(8'd10, 8'd10, 8'd10, 8'd10);
        check("stall1_data",  avg_data,  8'd10);
        check("stall1_valid", avg_valid, 1'b1);
        check("stall1_ovr",   overrun,   1'b0);
        step();
        blk4(8'd20, 8'd20, 8'd20, 8'd20);
        check("stall2_data",  avg_data,  8'd20);
        check("stall2_valid", avg_valid, 1'b1);
        check("stall2_ovr",   overrun,   1'b1);
        step();
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        @(negedge clk);
        check("clr_ovr",     overrun,   1'b0);
        check("held_data",   avg_data,  8'd20);
        check("held_valid",  avg_valid, 1'b1);
        step();
        avg_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("late_accept", avg_valid, 1'b0);
        step();

        // Hysteresis: 0xC8 sets, 0x80 holds, 0x30 clears
        blk4(8'hC8, 8'hC8, 8'hC8, 8'hC8);
        check("alarm_c8", alarm, 1'b1);
        step();
        blk4(8'h80, 8'h80, 8'h80, 8'h80);
        check("alarm_80", alarm, 1'b1);
        check("data_80",  avg_data, 8'h80);
        step();
        blk4(8'h30, 8'h30, 8'h30, 8'h30);
        check("alarm_30", alarm, 1'b0);
        step();

        // en dropped mid-block: the two partial samples must not leak in
        do_sample(8'd50);
        do_sample(8'd60);
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        blk4(8'd8, 8'd8, 8'd8, 8'd8);
        check("partial_data",  avg_data,  8'd8);
        check("partial_valid", avg_valid, 1'b1);
        step();

        // Load up valid/alarm/overrun, then reset mid-block
        avg_ready = 1'b0;
        blk4(8'hD0, 8'hD0, 8'hD0, 8'hD0);
        step();
        blk4(8'hD0, 8'hD0, 8'hD0, 8'hD0);
        check("pre_rst_ovr",   overrun, 1'b1);
        check("pre_rst_alarm", alarm,   1'b1);
        step();
        do_sample(8'd33);
        do_sample(8'd44);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_data",  avg_data,  8'h00);
        check("mid_rst_valid", avg_valid, 1'b0);
        check("mid_rst_alarm", alarm,     1'b0);
        check("mid_rst_ovr",   overrun,   1'b0);
        step();
        avg_ready = 1'b1;
        blk4(8'd20, 8'd40, 8'd60, 8'd80);
        check("post_rst_data",  avg_data,  8'd50);
        check("post_rst_valid", avg_valid, 1'b1);
        step();

`ifdef MINMAX_TRACK_EN
        // 5+200+7+9 = 221 -> 55
        blk4(8'd5, 8'd200, 8'd7, 8'd9);
        check("mm_data", avg_data, 8'd55);
        check("mm_min",  blk_min,  8'd5);
        check("mm_max",  blk_max,  8'd200);
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
